// File: rtl/disp_pkg.sv
// Shared types, constants and helpers for the display scan controller.
package disp_pkg;

    typedef enum logic [0:0] {GUARD, SHOW} scan_state_t;

    localparam int unsigned BCD_W      = 4;
    localparam logic [3:0]  BLANK_CODE = 4'hF;
    localparam int unsigned MAX_DIGITS = 8;

    // Blank leading zeros from the top digit down; digit 0 always survives.
    function automatic logic [BCD_W*MAX_DIGITS-1:0] lz_blank(
        input logic [BCD_W*MAX_DIGITS-1:0] d,
        input int                          n
    );
        logic [BCD_W*MAX_DIGITS-1:0] r;
        logic                        lead;
        r    = d;
        lead = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (i < n) begin
                if (lead && (r[BCD_W*i +: BCD_W] == '0)) begin
                    r[BCD_W*i +: BCD_W] = BLANK_CODE;
                end else begin
                    lead = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/slot_timer.sv
// Per-slot cycle counter: wraps every PRESCALE cycles and flags the frame boundary.
module slot_timer #(
    parameter  int unsigned PRESCALE = 50000,
    localparam int unsigned CNT_W    = $clog2(PRESCALE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             last_idx,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             boundary
);

    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        wrap     = (cnt == CNT_W'(PRESCALE - 1));
        cnt_d    = wrap ? '0 : cnt + 1'b1;
        boundary = wrap & last_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_d;
        end
    end

endmodule

// File: rtl/disp_scan_mux.sv
// Multiplexed 7-segment scan controller with frame-synchronous digit loads.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits at capture time.
module disp_scan_mux
    import disp_pkg::*;
#(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned DEADTIME = 500
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [BCD_W*N_DIGITS-1:0] digits_in,
    input  logic                      load,
    output logic                      load_ack,
    output logic [BCD_W-1:0]          bcd,
    output logic [N_DIGITS-1:0]       an,
    output logic                      frame_tick
);

    localparam int unsigned IDX_W = $clog2(N_DIGITS);
    localparam int unsigned CNT_W = $clog2(PRESCALE);
    localparam int unsigned DW    = BCD_W * N_DIGITS;

    scan_state_t       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DW-1:0]     shadow_q, shadow_d, stored;
    logic [N_DIGITS-1:0] an_d;
    logic [BCD_W-1:0]  bcd_d;
    logic [CNT_W-1:0]  cnt;
    logic              wrap, boundary, last_idx, capture, guard_exit;

    assign last_idx = (idx_q == IDX_W'(N_DIGITS - 1));

    slot_timer #(
        .PRESCALE(PRESCALE)
    ) u_slot_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .last_idx(last_idx),
        .cnt     (cnt),
        .wrap    (wrap),
        .boundary(boundary)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [BCD_W*MAX_DIGITS-1:0] blanked;
    assign blanked = lz_blank((BCD_W*MAX_DIGITS)'(digits_in), N_DIGITS);
    assign stored  = blanked[DW-1:0];
`else
    assign stored = digits_in;
`endif

    assign capture = boundary & load;
    // Leave GUARD one cycle early so SHOW lines up with cnt == DEADTIME.
    assign guard_exit = (DEADTIME == 0) || (cnt == CNT_W'(DEADTIME - 1));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = capture ? stored : shadow_q;
        an_d     = '1;
        bcd_d    = BLANK_CODE;

        if (wrap) begin
            idx_d = last_idx ? '0 : idx_q + 1'b1;
        end

        unique case (state_q)
            GUARD: if (guard_exit) state_d = SHOW;
            SHOW:  if (wrap && (DEADTIME != 0)) state_d = GUARD;
            default: state_d = GUARD;
        endcase

        // Outputs are computed from next-state values so they register in step with cnt.
        if (state_d == SHOW) begin
            an_d[idx_d] = 1'b0;
            bcd_d       = shadow_d[idx_d*BCD_W +: BCD_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= GUARD;
            idx_q      <= '0;
            shadow_q   <= {N_DIGITS{BLANK_CODE}};
            an         <= '1;
            bcd        <= BLANK_CODE;
            load_ack   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            an         <= an_d;
            bcd        <= bcd_d;
            load_ack   <= capture;
            frame_tick <= boundary;
        end
    end

endmodule

// File: tb/tb_disp_scan_mux.sv
// Self-checking bench for disp_scan_mux (N_DIGITS=4, PRESCALE=8, DEADTIME=2).
module tb_disp_scan_mux;

    localparam int N  = 4;
    localparam int P  = 8;
    localparam int D  = 2;
    localparam int FR = N * P;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] digits_in;
    logic        load_ack;
    logic [3:0]  bcd;
    logic [3:0]  an;
    logic        frame_tick;

    always #5 clk = ~clk;

    disp_scan_mux #(
        .N_DIGITS(N),
        .PRESCALE(P),
        .DEADTIME(D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .digits_in (digits_in),
        .load      (load),
        .load_ack  (load_ack),
        .bcd       (bcd),
        .an        (an),
        .frame_tick(frame_tick)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] bcd;
        logic       ack;
        logic       tick;
    } exp_t;

    typedef struct packed {
        logic [15:0] digits;
        logic [15:0] shown;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[4];
    int          checks;
    int          errors;
    int          cyc;
    logic [15:0] m_shadow;
    logic        ack_seen;

    function automatic logic [15:0] store(input logic [15:0] d);
        logic [15:0] r;
        r = d;
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = 3; i >= 1; i--) begin
            if (r[4*i +: 4] == 4'h0) r[4*i +: 4] = 4'hF;
            else break;
        end
`endif
        return r;
    endfunction

    function automatic exp_t expect_at(input int n, input logic ack);
        exp_t e;
        int   off;
        int   slot;
        off    = n % P;
        slot   = (n / P) % N;
        e.an   = (off < D) ? 4'hF : ~(4'b0001 << slot);
        e.bcd  = (off < D) ? 4'hF : m_shadow[4*slot +: 4];
        e.ack  = ack;
        e.tick = (n > 0) && (n % FR == 0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // Compare this cycle against the scoreboard, then queue the next cycle's expectation.
    task automatic step();
        exp_t e;
        logic cap;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty cyc=%0d got 0 entries want 1", cyc);
        end else begin
            e = sb.pop_front();
            chk("an", {28'd0, an}, {28'd0, e.an});
            chk("bcd", {28'd0, bcd}, {28'd0, e.bcd});
            chk("load_ack", {31'd0, load_ack}, {31'd0, e.ack});
            chk("frame_tick", {31'd0, frame_tick}, {31'd0, e.tick});
            chk("an_onehot", {31'd0, ($countones(~an) <= 1)}, 32'd1);
        end
        cap = (cyc % FR == FR - 1) && load;
        if (cap) m_shadow = store(digits_in);
        sb.push_back(expect_at(cyc + 1, cap));
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        m_shadow = 16'hFFFF;
        cyc = 0;
        repeat (3) @(negedge clk);
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_bcd", {28'd0, bcd}, 32'hF);
        chk("rst_ack", {31'd0, load_ack}, 32'd0);
        chk("rst_tick", {31'd0, frame_tick}, 32'd0);
        rst_n = 1'b1;
        sb.push_back(expect_at(0, 1'b0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got timeout want finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        load      = 1'b0;
        digits_in = 16'h0000;
        rst_n     = 1'b0;

        vecs[0] = '{digits: 16'h5678, shown: 16'h5678};
        vecs[1] = '{digits: 16'hA0B9, shown: 16'hA0B9};
`ifdef LEADING_ZERO_BLANK_EN
        vecs[2] = '{digits: 16'h0050, shown: 16'hFF50};
        vecs[3] = '{digits: 16'h0000, shown: 16'hFFF0};
`else
        vecs[2] = '{digits: 16'h0050, shown: 16'h0050};
        vecs[3] = '{digits: 16'h0000, shown: 16'h0000};
`endif

        @(negedge clk);
        do_reset();

        // Blank scan with no load, then async reset mid-SHOW of slot 1.
        repeat (45) step();
        chk("pre_rst_an", {28'd0, an}, 32'hD);
        #2 rst_n = 1'b0;
        #1;
        chk("async_an", {28'd0, an}, 32'hF);
        chk("async_bcd", {28'd0, bcd}, 32'hF);
        @(negedge clk);

        // Load requested right at reset release; held through the ack cycle.
        load      = 1'b1;
        digits_in = 16'h1234;
        do_reset();
        ack_seen = 1'b0;
        for (int i = 0; i < 40 && !ack_seen; i++) begin
            step();
            ack_seen = load_ack;
        end
        chk("ack_cycle32", cyc, 32);
        digits_in = 16'h9999;
        step();
        step();
        load = 1'b0;
        repeat (40) step();

        // Mid-frame loads from the vector table.
        for (int v = 0; v < 4; v++) begin
            while ((cyc / P) % N != 1) step();
            load      = 1'b1;
            digits_in = vecs[v].digits;
            ack_seen  = 1'b0;
            for (int i = 0; i < 64 && !ack_seen; i++) begin
                step();
                ack_seen = load_ack;
            end
            chk("ack_seen", {31'd0, ack_seen}, 32'd1);
            chk("ack_at_frame", cyc % FR, 0);
            load = 1'b0;
            for (int k = 0; k < FR; k++) begin
                step();
                if (cyc % P == 5)
                    chk("tbl_bcd", {28'd0, bcd}, {28'd0, vecs[v].shown[4*((cyc/P)%N) +: 4]});
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
